// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises CPU and video-DMA cycles onto the 68k SDRAM controller.
// Define ARB_TIMEOUT_EN to add the Dtack watchdog (TIMEOUT_CYCLES, Err output).
module sdram_port_arbiter #(
  parameter int VID_BURST_LIMIT = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Cpu_Req,
  input  logic [31:0] Cpu_Addr,
  input  logic [15:0] Cpu_WData,
  input  logic        Cpu_WE_L,
  input  logic        Cpu_UDS_L,
  input  logic        Cpu_LDS_L,
  output logic        Cpu_Done,
  output logic [15:0] Cpu_RData,
  input  logic        Vid_Req,
  input  logic [31:0] Vid_Addr,
  output logic        Vid_Done,
  output logic [15:0] Vid_RData,
  output logic        Mem_Sel_L,
  output logic        Mem_AS_L,
  output logic [31:0] Mem_Addr,
  output logic [15:0] Mem_DataIn,
  output logic        Mem_WE_L,
  output logic        Mem_UDS_L,
  output logic        Mem_LDS_L,
  input  logic [15:0] Mem_DataOut,
  input  logic        Mem_Dtack_L,
  output logic [1:0]  Grant,
  output logic        Err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_VID = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(VID_BURST_LIMIT);

  if (VID_BURST_LIMIT < 1 || VID_BURST_LIMIT > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("sdram_port_arbiter: parameter out of range");
  end

  state_t      r_state, w_state;
  logic [3:0]  r_starve, w_starve;
  logic        r_rel, w_rel;
  logic        r_sel_l, w_sel_l;
  logic [31:0] r_addr, w_addr;
  logic [15:0] r_wdata, w_wdata;
  logic        r_we_l, w_we_l;
  logic        r_uds_l, w_uds_l;
  logic        r_lds_l, w_lds_l;
  logic [1:0]  r_grant, w_grant;
  logic        r_cpu_done, w_cpu_done;
  logic        r_vid_done, w_vid_done;
  logic [15:0] r_cpu_rdata, w_cpu_rdata;
  logic [15:0] r_vid_rdata, w_vid_rdata;
  logic        r_err, w_err;
  logic        w_fin, w_cap;
  logic        w_vid_win;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  r_to_cnt, w_to_cnt;
`endif

  // Video wins unless the CPU has waited out a full video burst.
  assign w_vid_win = Vid_Req && !(Cpu_Req && r_starve == BURST_LIM);

  always_comb begin
    w_state     = r_state;
    w_starve    = r_starve;
    w_rel       = 1'b0;
    w_sel_l     = r_sel_l;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_we_l      = r_we_l;
    w_uds_l     = r_uds_l;
    w_lds_l     = r_lds_l;
    w_grant     = r_grant;
    w_cpu_done  = 1'b0;
    w_vid_done  = 1'b0;
    w_cpu_rdata = r_cpu_rdata;
    w_vid_rdata = r_vid_rdata;
    w_err       = 1'b0;
    w_fin       = 1'b0;
    w_cap       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_to_cnt    = '0;
`endif
    unique case (r_state)
      IDLE: begin
        if (!Cpu_Req) w_starve = '0;
        if (w_vid_win) begin
          w_state = GNT_VID;
          w_sel_l = 1'b0;
          w_addr  = Vid_Addr;
          w_we_l  = 1'b1;
          w_uds_l = 1'b0;
          w_lds_l = 1'b0;
          w_grant = 2'b10;
          if (Cpu_Req && r_starve < BURST_LIM)
            w_starve = r_starve + 4'd1;
        end else if (Cpu_Req) begin
          w_state  = GNT_CPU;
          w_sel_l  = 1'b0;
          w_addr   = Cpu_Addr;
          w_wdata  = Cpu_WData;
          w_we_l   = Cpu_WE_L;
          w_uds_l  = Cpu_UDS_L;
          w_lds_l  = Cpu_LDS_L;
          w_grant  = 2'b01;
          w_starve = '0;
        end
      end
      GNT_CPU, GNT_VID: begin
        if (!Mem_Dtack_L) begin
          w_fin = 1'b1;
          w_cap = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_fin = 1'b1;
          w_err = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + 8'd1;
        end
`endif
      end
      RELEASE: begin
        // r_rel marks that one RELEASE clock has already passed.
        if (r_rel && Mem_Dtack_L) w_state = IDLE;
        else w_rel = 1'b1;
      end
      default: w_state = IDLE;
    endcase

    if (w_fin) begin
      w_state    = RELEASE;
      w_sel_l    = 1'b1;
      w_we_l     = 1'b1;
      w_uds_l    = 1'b1;
      w_lds_l    = 1'b1;
      w_grant    = 2'b00;
      w_cpu_done = (r_state == GNT_CPU);
      w_vid_done = (r_state == GNT_VID);
    end
    if (w_cap && r_state == GNT_CPU) w_cpu_rdata = Mem_DataOut;
    if (w_cap && r_state == GNT_VID) w_vid_rdata = Mem_DataOut;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_rel       <= 1'b0;
      r_sel_l     <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we_l      <= 1'b1;
      r_uds_l     <= 1'b1;
      r_lds_l     <= 1'b1;
      r_grant     <= 2'b00;
      r_cpu_done  <= 1'b0;
      r_vid_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_starve    <= w_starve;
      r_rel       <= w_rel;
      r_sel_l     <= w_sel_l;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_we_l      <= w_we_l;
      r_uds_l     <= w_uds_l;
      r_lds_l     <= w_lds_l;
      r_grant     <= w_grant;
      r_cpu_done  <= w_cpu_done;
      r_vid_done  <= w_vid_done;
      r_cpu_rdata <= w_cpu_rdata;
      r_vid_rdata <= w_vid_rdata;
      r_err       <= w_err;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_to_cnt <= '0;
    else       r_to_cnt <= w_to_cnt;
  end
`endif

  assign Mem_Sel_L  = r_sel_l;
  assign Mem_AS_L   = r_sel_l;
  assign Mem_Addr   = r_addr;
  assign Mem_DataIn = r_wdata;
  assign Mem_WE_L   = r_we_l;
  assign Mem_UDS_L  = r_uds_l;
  assign Mem_LDS_L  = r_lds_l;
  assign Grant      = r_grant;
  assign Cpu_Done   = r_cpu_done;
  assign Vid_Done   = r_vid_done;
  assign Cpu_RData  = r_cpu_rdata;
  assign Vid_RData  = r_vid_rdata;
  assign Err        = r_err;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Two-port arbiter in front of the 68k SDRAM controller. It lets the 68000 CPU and the 800x480 video frame-buffer read DMA share the single controller bus interface. It serialises whole bus cycles, muxes address, data and strobes, and returns read data and a completion pulse to the owning requester. Video has priority, but a starvation guard bounds how long the CPU can be held off.

Parameters:
VID_BURST_LIMIT, 4, max consecutive video grants while Cpu_Req is pending before the CPU is forced in (1..15).
TIMEOUT_CYCLES, 255, Dtack watchdog limit in clocks; used only with ARB_TIMEOUT_EN (1..255).

Ports:
Clock  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-high reset.
Cpu_Req  in  1  CPU cycle request; held until Cpu_Done.
Cpu_Addr  in  32  CPU byte address.
Cpu_WData  in  16  CPU write data.
Cpu_WE_L  in  1  active-low write; high means read.
Cpu_UDS_L  in  1  active-low upper data strobe.
Cpu_LDS_L  in  1  active-low lower data strobe.
Cpu_Done  out  1  one-cycle completion pulse.
Cpu_RData  out  16  read data; valid when Cpu_Done is high.
Vid_Req  in  1  video read request; held until Vid_Done.
Vid_Addr  in  32  video byte address.
Vid_Done  out  1  one-cycle completion pulse.
Vid_RData  out  16  read data; valid when Vid_Done is high.
Mem_Sel_L  out  1  DramSelect_L to the controller.
Mem_AS_L  out  1  AS_L to the controller.
Mem_Addr  out  32  Address to the controller.
Mem_DataIn  out  16  DataIn to the controller.
Mem_WE_L  out  1  WE_L to the controller.
Mem_UDS_L  out  1  UDS_L to the controller.
Mem_LDS_L  out  1  LDS_L to the controller.
Mem_DataOut  in  16  DataOut from the controller.
Mem_Dtack_L  in  1  Dtack_L from the controller.
Grant  out  2  current owner: 00 none, 01 CPU, 10 video.
Err  out  1  timeout flag, pulses with Done.

Behaviour:
- Reset: async, active-high; takes effect immediately, including mid-cycle. Any in-flight transaction is abandoned with no Done pulse. Reset values:
  - Mem_Sel_L, Mem_AS_L, Mem_WE_L, Mem_UDS_L, Mem_LDS_L = 1
  - Mem_Addr, Mem_DataIn = 0
  - Cpu_Done, Vid_Done, Err = 0; Cpu_RData, Vid_RData = 0
  - Grant = 00; starvation counter = 0; state = IDLE
- All outputs are registered.
- FSM states: IDLE, GNT_CPU, GNT_VID, RELEASE.
- IDLE:
  - Only Vid_Req high -> GNT_VID.
  - Only Cpu_Req high -> GNT_CPU.
  - Both high -> GNT_CPU if starve_cnt == VID_BURST_LIMIT, else GNT_VID.
  - On the entering edge, latch the winner's address, data and strobes onto Mem_*, drive Mem_Sel_L = Mem_AS_L = 0 and set Grant. Mem_Sel_L therefore falls one clock after Req is first sampled high.
  - Video cycles always drive Mem_WE_L = 1, Mem_UDS_L = 0, Mem_LDS_L = 0.
- GNT_x: hold the Mem_* outputs stable and wait for Mem_Dtack_L sampled low. On that edge:
  - capture Mem_DataOut into x_RData (writes capture it too);
  - pulse x_Done for exactly one cycle;
  - drive Mem_Sel_L = Mem_AS_L = 1 and strobes/WE back to 1; go to RELEASE.
- RELEASE:
  - Grant = 00.
  - Stay a minimum of 2 clocks and until Mem_Dtack_L is sampled high, then go to IDLE.
  - The requester drops Req on the edge after it sees Done. A Req still high on return to IDLE is a new request.
- Starvation counter (4 bits, saturating at VID_BURST_LIMIT):
  - +1 on each video grant made while Cpu_Req is high.
  - Cleared on any CPU grant.
  - Cleared in IDLE when Cpu_Req is low.
- Requests arriving during GNT_x or RELEASE stay pending; they are never dropped.
- Done pulses never overlap; at most one Done is high in any cycle.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a cycle counter runs in GNT_x. If TIMEOUT_CYCLES clocks elapse without Mem_Dtack_L low, the block pulses x_Done and Err together for 1 cycle, leaves x_RData unchanged, deasserts Mem_* and enters RELEASE. RELEASE still waits for Mem_Dtack_L high.
- Undefined: no counter, Err is tied to 0, and GNT_x waits indefinitely.

Test Plan:
- Reset asserted mid GNT_VID -> Mem_Sel_L = 1 and Grant = 00 immediately; no Vid_Done; after release, IDLE with all outputs at reset values.
- Cpu_Req write to 0x00F00010, data 0x1234, UDS_L/LDS_L = 0/1; Dtack low 5 clocks later -> Mem_Sel_L low 1 clock after Req; Mem_Addr 0x00F00010, Mem_DataIn 0x1234, Mem_WE_L 0; one Cpu_Done pulse.
- Vid_Req read at 0x00100000; controller returns 0xABCD -> Vid_RData = 0xABCD with Vid_Done; Mem_WE_L = 1, both strobes 0.
- Cpu_Req and Vid_Req held continuously with VID_BURST_LIMIT = 4 -> grant order V,V,V,V,C,V,V,V,V,C.
- Simultaneous first request from both with counter 0 -> video granted; CPU stays pending and is granted right after the RELEASE that follows video.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 10, Dtack held high -> Cpu_Done and Err pulse 10 clocks after grant; Cpu_RData unchanged.
